apb_fabric_ctrl: RTL and testbench

Fabric-side APB3 controller between the MSS fabric APB master port (MSSP*) and up to eight fabric peripheral slaves. It decodes each MSS access to one slave slot, re-issues it as a registered downstream APB3 transfer, and returns read data, ready and error to the MSS. Unmapped slots and hung slaves are turned into a bounded error response, so the Cortex-M3 never stalls indefinitely. It runs on FAB_CLK.

---
 rtl/apb_fabric_pkg.sv | 21 ++
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/apb_fabric_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_apb_fabric_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_fabric_pkg.sv
// -----------------------------------------------------------------------------
// apb_fabric_pkg
// Shared definitions for the fabric-side APB3 controller: FSM state encoding,
// data and slot-index widths, and the data value returned on any error.
// -----------------------------------------------------------------------------
package apb_fabric_pkg;

    localparam int DW   = 32;   // APB data width
    localparam int IDXW = 3;    // slot index width (up to eight slots)

    // Read data returned on writes and on every error response.
    localparam logic [DW-1:0] ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Counts downstream wait cycles. The count holds once it reaches TIMEOUT so it
// can never wrap back below the limit while a slave stays hung.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_clr      clear the count (start of a new downstream transfer)
//   i_en       count one cycle
//   o_expired  count equals TIMEOUT
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [15:0] r_count;
    logic        w_at_limit;

    assign w_at_limit = (r_count == 16'(TIMEOUT));
    assign o_expired  = w_at_limit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/apb_fabric_ctrl.sv
// -----------------------------------------------------------------------------
// apb_fabric_ctrl
// Bridges the MSS fabric APB3 master port to up to eight fabric APB3 slaves.
// Each MSS access is decoded to a slot, re-issued as a registered downstream
// transfer, and answered with ready/data/error. Unmapped slots and hung slaves
// both produce a bounded error response.
//
// Handshake: an MSS request is accepted only in IDLE, on MSSPSEL=1 with
// MSSPENABLE=0. The response is a single-cycle MSSPREADY pulse carrying
// MSSPRDATA/MSSPSLVERR; those two are zero whenever MSSPREADY is low.
// Downstream, S_PSEL is one-hot for the SETUP and ACCESS cycles only and the
// selected slot finishes the access by raising its S_PREADY bit.
//
// Ports:
//   FAB_CLK, FAB_RESET                      clock, sync active-high reset
//   MSSPSEL/ENABLE/WRITE/ADDR/WDATA         MSS request
//   MSSPRDATA/MSSPREADY/MSSPSLVERR          MSS response (registered)
//   S_PSEL/PENABLE/PWRITE/PADDR/PWDATA      downstream request (registered)
//   S_PRDATA/S_PREADY/S_PSLVERR             per-slot downstream response
//   ERR_CNT                                 saturating error-response count
//   o_dbg_state                             current FSM state
// -----------------------------------------------------------------------------
module apb_fabric_ctrl
    import apb_fabric_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SLV_AW  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 FAB_CLK,
    input  logic                 FAB_RESET,
    input  logic                 MSSPSEL,
    input  logic                 MSSPENABLE,
    input  logic                 MSSPWRITE,
    input  logic [31:0]          MSSPADDR,
    input  logic [DW-1:0]        MSSPWDATA,
    output logic [DW-1:0]        MSSPRDATA,
    output logic                 MSSPREADY,
    output logic                 MSSPSLVERR,
    output logic [NSLV-1:0]      S_PSEL,
    output logic                 S_PENABLE,
    output logic                 S_PWRITE,
    output logic [SLV_AW-1:0]    S_PADDR,
    output logic [DW-1:0]        S_PWDATA,
    input  logic [NSLV*DW-1:0]   S_PRDATA,
    input  logic [NSLV-1:0]      S_PREADY,
    input  logic [NSLV-1:0]      S_PSLVERR,
    output logic [7:0]           ERR_CNT,
    output apb_state_t           o_dbg_state
);

    apb_state_t          r_state, w_next;

    // Request latches
    logic [IDXW-1:0]     r_idx;
    logic [SLV_AW-1:0]   r_addr;
    logic                r_write;
    logic [DW-1:0]       r_wdata;
    logic                r_dec_err;

    // Registered outputs
    logic [NSLV-1:0]     r_psel;
    logic                r_penable;
    logic                r_mss_ready;
    logic                r_mss_err;
    logic [DW-1:0]       r_mss_rdata;
    logic [7:0]          r_err_cnt;

    logic [IDXW-1:0]     w_in_idx;
    logic                w_in_valid;
    logic                w_setup;
    logic [IDXW-1:0]     w_sel_idx;
    logic [NSLV-1:0]     w_onehot;
    logic                w_slv_ready;
    logic                w_slv_err;
    logic [DW-1:0]       w_slv_rdata;
    logic                w_expired;
    logic                w_fire;
    logic                w_resp_err;
    logic [DW-1:0]       w_resp_data;
    logic                w_unused_addr;

    assign w_in_idx      = MSSPADDR[SLV_AW+2:SLV_AW];
    assign w_in_valid    = ({1'b0, w_in_idx} < 4'(NSLV));
    assign w_setup       = MSSPSEL && !MSSPENABLE;
    assign w_unused_addr = ^MSSPADDR[31:SLV_AW+3];

    // The select must be ready on the cycle after acceptance, before the
    // index latch is visible, so IDLE decodes straight from the MSS address.
    assign w_sel_idx = (r_state == ST_IDLE) ? w_in_idx : r_idx;

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < int'(NSLV); k++) begin
            w_onehot[k] = (w_sel_idx == IDXW'(k));
        end
    end

    // Response mux for the slot currently in flight.
    always_comb begin
        w_slv_ready = 1'b0;
        w_slv_err   = 1'b0;
        w_slv_rdata = '0;
        for (int k = 0; k < int'(NSLV); k++) begin
            if (r_idx == IDXW'(k)) begin
                w_slv_ready = S_PREADY[k];
                w_slv_err   = S_PSLVERR[k];
                w_slv_rdata = S_PRDATA[DW*k +: DW];
            end
        end
    end

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (FAB_CLK),
        .i_rst     (FAB_RESET),
        .i_clr     (w_next == ST_SETUP),
        .i_en      (r_state == ST_ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_fire marks the edge that launches the MSSPREADY pulse. A decode error
    // skips the downstream transfer; its response is loaded while in RESP, so
    // its pulse lands one cycle after RESP, two cycles after the setup phase.
    always_comb begin
        w_next      = r_state;
        w_fire      = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_data = ERR_DATA;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_next = w_in_valid ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_slv_ready) begin
                    w_next      = ST_RESP;
                    w_fire      = 1'b1;
                    w_resp_err  = w_slv_err;
                    w_resp_data = (r_write || w_slv_err) ? ERR_DATA : w_slv_rdata;
                end else if (w_expired) begin
                    w_next     = ST_RESP;
                    w_fire     = 1'b1;
                    w_resp_err = 1'b1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
                if (r_dec_err) begin
                    w_fire     = 1'b1;
                    w_resp_err = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_idx       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_dec_err   <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_mss_ready <= 1'b0;
            r_mss_err   <= 1'b0;
            r_mss_rdata <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_setup) begin
                r_idx     <= w_in_idx;
                r_addr    <= MSSPADDR[SLV_AW-1:0];
                r_write   <= MSSPWRITE;
                r_wdata   <= MSSPWDATA;
                r_dec_err <= !w_in_valid;
            end
            r_psel      <= (w_next == ST_SETUP || w_next == ST_ACCESS) ? w_onehot : '0;
            r_penable   <= (w_next == ST_ACCESS);
            r_mss_ready <= w_fire;
            r_mss_err   <= w_fire && w_resp_err;
            r_mss_rdata <= w_fire ? w_resp_data : ERR_DATA;
            if (w_fire && w_resp_err && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign MSSPRDATA   = r_mss_rdata;
    assign MSSPREADY   = r_mss_ready;
    assign MSSPSLVERR  = r_mss_err;
    assign S_PSEL      = r_psel;
    assign S_PENABLE   = r_penable;
    assign S_PWRITE    = r_write;
    assign S_PADDR     = r_addr;
    assign S_PWDATA    = r_wdata;
    assign ERR_CNT     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_fabric_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_fabric_ctrl
// Directed bench for apb_fabric_ctrl with NSLV=4, SLV_AW=8, TIMEOUT=255.
// Cycle 0 is the cycle in which the MSS setup phase is driven; inputs are
// driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_fabric_ctrl;
    import apb_fabric_pkg::*;

    localparam int NSLV = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic               psel, penable, pwrite;
    logic [31:0]        paddr, pwdata;
    logic [31:0]        prdata;
    logic               pready, pslverr;
    logic [NSLV-1:0]    s_psel;
    logic               s_penable, s_pwrite;
    logic [7:0]         s_paddr;
    logic [31:0]        s_pwdata;
    logic [NSLV*32-1:0] s_prdata;
    logic [NSLV-1:0]    s_pready, s_pslverr;
    logic [7:0]         err_cnt;
    apb_state_t         dbg_state;

    apb_fabric_ctrl #(
        .NSLV    (NSLV),
        .SLV_AW  (8),
        .TIMEOUT (255)
    ) dut (
        .FAB_CLK     (clk),
        .FAB_RESET   (rst),
        .MSSPSEL     (psel),
        .MSSPENABLE  (penable),
        .MSSPWRITE   (pwrite),
        .MSSPADDR    (paddr),
        .MSSPWDATA   (pwdata),
        .MSSPRDATA   (prdata),
        .MSSPREADY   (pready),
        .MSSPSLVERR  (pslverr),
        .S_PSEL      (s_psel),
        .S_PENABLE   (s_penable),
        .S_PWRITE    (s_pwrite),
        .S_PADDR     (s_paddr),
        .S_PWDATA    (s_pwdata),
        .S_PRDATA    (s_prdata),
        .S_PREADY    (s_pready),
        .S_PSLVERR   (s_pslverr),
        .ERR_CNT     (err_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mss_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
    endtask

    task automatic mss_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
    endtask

    task automatic set_slot(input int k, input logic [31:0] d);
        s_prdata[32*k +: 32] = d;
    endtask

    // ---------------- stimulus ----------------
    int          cyc;
    logic        multi_sel;
    logic [7:0]  exp_cnt;

    initial begin
        rst       = 1'b1;
        s_prdata  = '0;
        s_pready  = '0;
        s_pslverr = '0;
        mss_idle();
        step(); step(); step();

        // Reset state
        chk("rst_ready",  32'(pready),    32'h0);
        chk("rst_slverr", 32'(pslverr),   32'h0);
        chk("rst_rdata",  prdata,         32'h0);
        chk("rst_psel",   32'(s_psel),    32'h0);
        chk("rst_pen",    32'(s_penable), 32'h0);
        chk("rst_errcnt", 32'(err_cnt),   32'h0);
        chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();

        // Write slot 1, zero-wait slave; read bus carries junk that must be ignored
        s_pready = 4'b0010;
        set_slot(1, 32'hAAAA5555);
        mss_setup(1'b1, 32'h0000_0104, 32'hDEADBEEF);     // cycle 0
        step();                                            // cycle 1
        chk("wr_c1_psel",  32'(s_psel),    32'h2);
        chk("wr_c1_pen",   32'(s_penable), 32'h0);
        chk("wr_c1_paddr", 32'(s_paddr),   32'h04);
        chk("wr_c1_wdata", s_pwdata,       32'hDEADBEEF);
        chk("wr_c1_pwr",   32'(s_pwrite),  32'h1);
        chk("wr_c1_ready", 32'(pready),    32'h0);
        penable = 1'b1;
        step();                                            // cycle 2
        chk("wr_c2_psel",  32'(s_psel),    32'h2);
        chk("wr_c2_pen",   32'(s_penable), 32'h1);
        chk("wr_c2_ready", 32'(pready),    32'h0);
        step();                                            // cycle 3
        chk("wr_c3_ready", 32'(pready),    32'h1);
        chk("wr_c3_err",   32'(pslverr),   32'h0);
        chk("wr_c3_rdata", prdata,         32'h0);
        chk("wr_c3_psel",  32'(s_psel),    32'h0);
        s_pready = '0;
        step();                                            // cycle 4
        chk("wr_c4_ready", 32'(pready),    32'h0);

        // Back-to-back read of slot 3, two wait cycles
        mss_setup(1'b0, 32'h0000_0310, 32'h0);            // cycle 0
        step();                                            // cycle 1
        chk("rd_c1_psel",  32'(s_psel),    32'h8);
        chk("rd_c1_paddr", 32'(s_paddr),   32'h10);
        chk("rd_c1_pwr",   32'(s_pwrite),  32'h0);
        penable = 1'b1;
        step();                                            // cycle 2: wait
        chk("rd_c2_ready", 32'(pready),    32'h0);
        step();                                            // cycle 3: wait
        chk("rd_c3_ready", 32'(pready),    32'h0);
        step();                                            // cycle 4: slave ready
        s_pready = 4'b1000;
        set_slot(3, 32'h12345678);
        chk("rd_c4_ready", 32'(pready),    32'h0);
        step();                                            // cycle 5
        s_pready = '0;
        chk("rd_c5_ready", 32'(pready),    32'h1);
        chk("rd_c5_rdata", prdata,         32'h12345678);
        chk("rd_c5_err",   32'(pslverr),   32'h0);
        step();
        mss_idle();
        step();

        // Decode error: slot 5 is unpopulated
        chk("dec_cnt0", 32'(err_cnt), 32'h0);
        mss_setup(1'b0, 32'h0000_0500, 32'h0);            // cycle 0
        step();                                            // cycle 1
        chk("dec_c1_psel",  32'(s_psel), 32'h0);
        chk("dec_c1_ready", 32'(pready), 32'h0);
        penable = 1'b1;
        step();                                            // cycle 2
        chk("dec_c2_ready", 32'(pready),  32'h1);
        chk("dec_c2_err",   32'(pslverr), 32'h1);
        chk("dec_c2_rdata", prdata,       32'h0);
        chk("dec_c2_psel",  32'(s_psel),  32'h0);
        chk("dec_c2_cnt",   32'(err_cnt), 32'h1);
        step();
        mss_idle();
        chk("dec_c3_ready", 32'(pready), 32'h0);
        step();

        // Slot 0 never ready: timeout after 255 wait cycles
        mss_setup(1'b0, 32'h0000_0000, 32'h0);            // cycle 0
        cyc       = 0;
        multi_sel = 1'b0;
        while (cyc < 400) begin
            step();
            cyc++;
            penable = 1'b1;
            if ($countones(s_psel) > 1) multi_sel = 1'b1;
            if (pready) break;
        end
        chk("to_cycle",  32'(cyc),       32'd258);
        chk("to_err",    32'(pslverr),   32'h1);
        chk("to_rdata",  prdata,         32'h0);
        chk("to_psel",   32'(s_psel),    32'h0);
        chk("to_cnt",    32'(err_cnt),   32'h2);
        chk("to_onehot", 32'(multi_sel), 32'h0);
        step();
        mss_idle();
        step();

        // Slave error on first access cycle
        s_pready  = 4'b0100;
        s_pslverr = 4'b0100;
        set_slot(2, 32'hCAFEF00D);
        mss_setup(1'b0, 32'h0000_0220, 32'h0);            // cycle 0
        step();                                            // cycle 1
        penable = 1'b1;
        step();                                            // cycle 2
        chk("se_c2_ready", 32'(pready),  32'h0);
        step();                                            // cycle 3
        chk("se_c3_ready", 32'(pready),  32'h1);
        chk("se_c3_err",   32'(pslverr), 32'h1);
        chk("se_c3_rdata", prdata,       32'h0);
        chk("se_c3_cnt",   32'(err_cnt), 32'h3);
        s_pready  = '0;
        s_pslverr = '0;
        step();
        mss_idle();
        step();

        // 300 forced decode errors: counter saturates
        exp_cnt = 8'd3;
        for (int i = 0; i < 300; i++) begin
            mss_setup(1'b0, 32'h0000_0700, 32'h0);
            step();
            penable = 1'b1;
            step();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (i == 199) chk("sat_mid", 32'(err_cnt), 32'(exp_cnt));
            step();
            mss_idle();
        end
        step();
        chk("sat_cnt",     32'(err_cnt), 32'd255);
        chk("sat_exp_cnt", 32'(err_cnt), 32'(exp_cnt));

        // Reset during ACCESS of a slot-2 write
        mss_setup(1'b1, 32'h0000_0208, 32'h55AA55AA);     // cycle 0
        step();                                            // cycle 1
        penable = 1'b1;
        step();                                            // cycle 2: ACCESS
        chk("ra_c2_psel", 32'(s_psel),    32'h4);
        chk("ra_c2_pen",  32'(s_penable), 32'h1);
        rst = 1'b1;
        step();
        chk("ra_psel",   32'(s_psel),    32'h0);
        chk("ra_pen",    32'(s_penable), 32'h0);
        chk("ra_ready",  32'(pready),    32'h0);
        chk("ra_wdata",  s_pwdata,       32'h0);
        chk("ra_paddr",  32'(s_paddr),   32'h0);
        chk("ra_cnt",    32'(err_cnt),   32'h0);
        chk("ra_state",  32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        mss_idle();
        step();

        // Normal read of slot 2 after reset release
        s_pready = 4'b0100;
        set_slot(2, 32'h0BADF00D);
        mss_setup(1'b0, 32'h0000_02FC, 32'h0);            // cycle 0
        step();                                            // cycle 1
        chk("pr_c1_psel",  32'(s_psel),  32'h4);
        chk("pr_c1_paddr", 32'(s_paddr), 32'hFC);
        penable = 1'b1;
        step();                                            // cycle 2
        step();                                            // cycle 3
        chk("pr_c3_ready", 32'(pready),  32'h1);
        chk("pr_c3_rdata", prdata,       32'h0BADF00D);
        chk("pr_c3_err",   32'(pslverr), 32'h0);
        s_pready = '0;
        step();
        mss_idle();
        chk("pr_c4_ready", 32'(pready),    32'h0);
        chk("pr_c4_state", 32'(dbg_state), 32'(ST_IDLE));
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
